// File: rtl/uart_ctrl_if.sv
// Handshake and UART-facing signal bundle for uart_ctrl.
// The master side is the controller; the slave side is the requesters, the consumer and the uart block.
interface uart_ctrl_if;
    logic       req0_valid;
    logic [7:0] req0_data;
    logic       req0_ready;
    logic       req1_valid;
    logic [7:0] req1_data;
    logic       req1_ready;
    logic       uart_write;
    logic [7:0] uart_datain;
    logic       uart_txrdy;
    logic       uart_read;
    logic [7:0] uart_dataout;
    logic       uart_rxrdy;
    logic       uart_parityerr;
    logic       uart_framingerr;
    logic       uart_overrun;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic [2:0] rx_err;
    logic       rx_pop;
    logic [7:0] rx_drop_cnt;
    logic       tx_timeout;

    modport master (
        input  req0_valid, req0_data, req1_valid, req1_data,
        output req0_ready, req1_ready,
        output uart_write, uart_datain, uart_read,
        input  uart_txrdy, uart_dataout, uart_rxrdy,
        input  uart_parityerr, uart_framingerr, uart_overrun,
        output rx_valid, rx_data, rx_err, rx_drop_cnt, tx_timeout,
        input  rx_pop
    );

    modport slave (
        output req0_valid, req0_data, req1_valid, req1_data,
        input  req0_ready, req1_ready,
        input  uart_write, uart_datain, uart_read,
        output uart_txrdy, uart_dataout, uart_rxrdy,
        output uart_parityerr, uart_framingerr, uart_overrun,
        input  rx_valid, rx_data, rx_err, rx_drop_cnt, tx_timeout,
        output rx_pop
    );
endinterface

// File: rtl/uart_ctrl.sv
// Host-side uart controller: round-robin TX sharing between two requesters,
// RX drain into a small FIFO with per-byte error flags.
module uart_ctrl #(
    parameter int RX_DEPTH     = 4,
    parameter int BUSY_TIMEOUT = 32
) (
    input  logic          mclkx16,
    input  logic          reset,
    uart_ctrl_if.master   u
);
    localparam int AW = $clog2(RX_DEPTH);
    localparam int CW = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [1:0] {TX_IDLE, TX_STROBE, TX_WAIT_BUSY, TX_WAIT_DONE} tx_st_t;
    typedef enum logic [1:0] {RX_IDLE, RX_ACK, RX_WAIT_CLR} rx_st_t;

    tx_st_t        tx_st;
    rx_st_t        rx_st;
    logic          last;
    logic          write_q, read_q, timeout_q;
    logic [7:0]    datain_q;
    logic [CW-1:0] cnt;
    logic [7:0]    drop_cnt;

    // ---------------- TX arbitration ----------------
    // last=1 means req1 was served last, so req0 wins a tie.
    logic g0, g1, tx_idle, rdy0, rdy1, tx_acc;
    assign g0      = u.req0_valid & (~u.req1_valid | last);
    assign g1      = u.req1_valid & (~u.req0_valid | ~last);
    assign tx_idle = (tx_st == TX_IDLE);
    assign rdy0    = tx_idle & u.uart_txrdy & g0;
    assign rdy1    = tx_idle & u.uart_txrdy & g1;
    assign tx_acc  = rdy0 | rdy1;

    always_ff @(posedge mclkx16 or negedge reset) begin
        if (!reset) begin
            tx_st     <= TX_IDLE;
            last      <= 1'b1;
            write_q   <= 1'b1;
            datain_q  <= 8'h00;
            cnt       <= '0;
            timeout_q <= 1'b0;
        end else begin
            case (tx_st)
                TX_IDLE: if (tx_acc) begin
                    datain_q <= rdy0 ? u.req0_data : u.req1_data;
                    last     <= rdy1;
                    write_q  <= 1'b0;
                    tx_st    <= TX_STROBE;
                end
                TX_STROBE: begin
                    write_q <= 1'b1;
                    cnt     <= '0;
                    tx_st   <= TX_WAIT_BUSY;
                end
                TX_WAIT_BUSY: begin
                    if (!u.uart_txrdy)
                        tx_st <= TX_WAIT_DONE;
                    else if (cnt == CW'(BUSY_TIMEOUT - 1)) begin
                        timeout_q <= 1'b1;
                        tx_st     <= TX_IDLE;
                    end else
                        cnt <= cnt + 1'b1;
                end
                TX_WAIT_DONE: if (u.uart_txrdy) tx_st <= TX_IDLE;
                default: tx_st <= TX_IDLE;
            endcase
        end
    end

    // ---------------- RX capture and FIFO ----------------
    logic [10:0]   mem [RX_DEPTH];
    logic [AW:0]   wptr, rptr;
    logic          empty, full, push, pop, wr_en, drop;
    logic [10:0]   head;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign push  = (rx_st == RX_IDLE) & u.uart_rxrdy;
    assign pop   = u.rx_pop & ~empty;
    // A pop on a full FIFO frees the slot the simultaneous push needs.
    assign wr_en = push & (~full | pop);
    assign drop  = push & full & ~pop;
    assign head  = mem[rptr[AW-1:0]];

    always_ff @(posedge mclkx16) begin
        if (wr_en)
            mem[wptr[AW-1:0]] <= {u.uart_overrun, u.uart_framingerr, u.uart_parityerr, u.uart_dataout};
    end

    always_ff @(posedge mclkx16 or negedge reset) begin
        if (!reset) begin
            rx_st    <= RX_IDLE;
            read_q   <= 1'b1;
            wptr     <= '0;
            rptr     <= '0;
            drop_cnt <= 8'h00;
        end else begin
            if (wr_en) wptr <= wptr + 1'b1;
            if (pop)   rptr <= rptr + 1'b1;
            if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 1'b1;
            case (rx_st)
                RX_IDLE: if (u.uart_rxrdy) begin
                    read_q <= 1'b0;
                    rx_st  <= RX_ACK;
                end
                RX_ACK: begin
                    read_q <= 1'b1;
                    rx_st  <= RX_WAIT_CLR;
                end
                RX_WAIT_CLR: if (!u.uart_rxrdy) rx_st <= RX_IDLE;
                default: rx_st <= RX_IDLE;
            endcase
        end
    end

    assign u.req0_ready  = rdy0;
    assign u.req1_ready  = rdy1;
    assign u.uart_write  = write_q;
    assign u.uart_datain = datain_q;
    assign u.uart_read   = read_q;
    assign u.rx_valid    = ~empty;
    assign u.rx_data     = empty ? 8'h00 : head[7:0];
    assign u.rx_err      = empty ? 3'b000 : head[10:8];
    assign u.rx_drop_cnt = drop_cnt;
    assign u.tx_timeout  = timeout_q;
endmodule

// File: doc/uart_ctrl.md
# uart_ctrl

Host-side controller for the `uart` block. It shares the UART transmitter between two byte requesters with round-robin arbitration and generates the active-low `write` strobe. It drains the receiver through the active-low `read` strobe into a small RX FIFO, keeping per-byte error flags. It connects directly to the `uart` ports and to on-chip requesters and consumers.

## Interface
- `RX_DEPTH`, default 4: RX FIFO entries; must be a power of 2, ≥2.
- `BUSY_TIMEOUT`, default 32: cycles to wait for `uart_txrdy` to fall after a write strobe.

Ports:
- `mclkx16` in 1: sole clock, the same master clock as `uart`.
- `reset` in 1: asynchronous, active-low reset.
- `req0_valid` in 1 / `req0_data` in 8 / `req0_ready` out 1: requester 0 TX byte handshake.
- `req1_valid` in 1 / `req1_data` in 8 / `req1_ready` out 1: requester 1 TX byte handshake.
- `uart_write` out 1: to `uart.write`, active-low.
- `uart_datain` out 8: to `uart.datain`.
- `uart_txrdy` in 1: from `uart.txrdy`; 1 = transmitter idle.
- `uart_read` out 1: to `uart.read`, active-low.
- `uart_dataout` in 8, `uart_rxrdy` in 1, `uart_parityerr` in 1, `uart_framingerr` in 1, `uart_overrun` in 1: from `uart`.
- `rx_valid` out 1: FIFO not empty.
- `rx_data` out 8: FIFO head byte.
- `rx_err` out 3: head flags {overrun, framing, parity}.
- `rx_pop` in 1: consume the head when `rx_valid`=1.
- `rx_drop_cnt` out 8: bytes dropped on a full FIFO; saturates at 255.
- `tx_timeout` out 1: sticky flag; set when a busy timeout fires.

## Operation

**TX FSM** (states TX_IDLE, TX_STROBE, TX_WAIT_BUSY, TX_WAIT_DONE)
- **TX_IDLE**
  - `reqN_ready` is combinational: (state==TX_IDLE) & `uart_txrdy` & (grant==N).
  - Grant logic:
    - Only one requester valid: grant goes to it.
    - Both valid: grant goes to the requester not served last.
    - `last` resets to 1, so req0 wins the first tie.
  - Accept on `valid & ready`:
    - latch data into `uart_datain`;
    - update `last`;
    - go to TX_STROBE.
- **TX_STROBE**
  - `uart_write`=0 for exactly this one cycle.
  - Then go to TX_WAIT_BUSY and clear the timeout counter.
- **TX_WAIT_BUSY**
  - `uart_txrdy`=0: go to TX_WAIT_DONE.
  - Counter reaches `BUSY_TIMEOUT` while `uart_txrdy` is still 1: set `tx_timeout` and go to TX_IDLE.
- **TX_WAIT_DONE**
  - `uart_txrdy`=1: go to TX_IDLE.
- `uart_datain` holds its value from acceptance until the next acceptance.

**RX FSM** (states RX_IDLE, RX_ACK, RX_WAIT_CLR)
- **RX_IDLE**
  - On `uart_rxrdy`=1, capture {flags, `uart_dataout`}.
  - Push the captured entry into the FIFO if space exists. Otherwise drop it and increment `rx_drop_cnt` (saturating).
  - Go to RX_ACK.
- **RX_ACK**
  - `uart_read`=0 for exactly one cycle.
  - Then go to RX_WAIT_CLR.
- **RX_WAIT_CLR**
  - `uart_rxrdy`=0: go to RX_IDLE. This prevents a double capture of one byte.

**RX FIFO**
- Circular buffer with `RX_DEPTH` entries of 11 bits each.
- Read and write pointers are log2(RX_DEPTH)+1 bits wide, for the full/empty distinction.
- Push and pop in the same cycle:
  - not empty and not full: both happen; occupancy unchanged;
  - full: the pop frees the slot, so the push succeeds and nothing is dropped;
  - empty: the push only happens; `rx_pop` is ignored because `rx_valid`=0.
- `rx_pop` while `rx_valid`=0 is ignored.

## Timing
- Reset values:
  - `uart_write`=1, `uart_read`=1;
  - `uart_datain`=0, `rx_data`=0, `rx_err`=0;
  - `rx_valid`=0, `req0_ready`=0, `req1_ready`=0;
  - `rx_drop_cnt`=0, `tx_timeout`=0;
  - both FSMs in their IDLE states;
  - FIFO empty.
- Reset asserted mid-operation aborts any strobe immediately (outputs return to reset values asynchronously) and discards FIFO contents.
- TX latency:
  - acceptance at edge N;
  - `uart_write` low during cycle N+1;
  - earliest next acceptance at cycle N+4, given `uart_txrdy` falls in N+2 and rises in N+3.
- RX latency:
  - `uart_rxrdy` seen at edge M;
  - FIFO entry visible (`rx_valid`=1) after edge M, i.e. in cycle M+1;
  - `uart_read` low during cycle M+1.
- `rx_data` and `rx_err` are driven combinationally from the head entry.
- TX and RX FSMs are independent. Simultaneous TX acceptance and RX capture are both serviced in the same cycle.

## Test plan
- **Reset state**: Assert `reset`=0, then release it. Check every output against the reset values in Timing, with `uart_write`=`uart_read`=1.
- **Round-robin tie**:
  - Stimulus: `req0`=0x41 and `req1`=0x42 both held valid; UART model drops `txrdy` 2 cycles after a write.
  - Required response:
    - bytes go out in the order 0x41, 0x42, 0x41, …;
    - each `uart_write` low pulse is exactly 1 cycle.
- **RX capture with errors**:
  - Stimulus: model presents 0xA5 with `parityerr`=1 and raises `rxrdy`.
  - Required response: one `uart_read` pulse; `rx_valid`=1; `rx_data`=0xA5; `rx_err`=3'b001.
  - Then: `rx_pop` one cycle, after which `rx_valid`=0.
- **FIFO overflow**:
  - Stimulus: 6 bytes 0x01–0x06 with no pops (`RX_DEPTH`=4).
  - Required response: `rx_drop_cnt`=2; popping yields 0x01–0x04.
- **Full with simultaneous pop**:
  - Stimulus: FIFO full; a byte arrives in the same cycle as `rx_pop`.
  - Required response: no drop; FIFO still full; new byte at the tail.
- **Busy timeout**:
  - Stimulus: model never drops `txrdy` after a write.
  - Required response: `tx_timeout`=1 after 32 cycles; FSM back in TX_IDLE; next request accepted.
